uart_tx_string_arbiter: RTL

- Shares one UART string transmitter (the `{{...}}` framed TX side of the string handler) between N independent requesters.
- Each requester posts a string/length job; the block round-robin schedules jobs onto the downstream tx interface, one frame at a time.
- It returns a per-requester done/error pulse.
- Sits between application producers (status reporters, measurement dumps) and the string handler's tx_string/tx_length/tx_req/tx_busy/tx_done port group.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_string_arbiter_rr_pick.sv | 24 ++
 rtl/uart_tx_string_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART string TX path: arbiter state encoding,
// frame delimiters used by the string handler, and the default abort timeout.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_ISSUE     = 5'b00010,
    ST_WAIT_BUSY = 5'b00100,
    ST_WAIT_DONE = 5'b01000,
    ST_RELEASE   = 5'b10000
  } arb_state_e;

  localparam logic [7:0] FRAME_OPEN  = 8'h7B;  // '{'
  localparam logic [7:0] FRAME_CLOSE = 8'h7D;  // '}'

  localparam int TIMEOUT_CYC_DEF = 2_000_000;

  // Bytes on the wire for a payload of len bytes: "{{" + payload + "}}".
  function automatic int unsigned frame_len(input logic [7:0] len);
    return 32'(len) + 32'd4;
  endfunction

endpackage

// File: rtl/uart_tx_string_arbiter_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or above rr_ptr,
// wrapping to 0. rr_ptr is expected to stay below N_REQ.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [2:0]       rr_ptr,
  output logic             found,
  output logic [2:0]       index
);

  // Walk offsets from the far end down so the smallest offset wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        index = 3'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_string_arbiter.sv
// Round-robin arbiter sharing one framed UART string transmitter between
// N_REQ requesters; one downstream frame outstanding at a time.
module uart_tx_string_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int STR_W       = 1024,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [N_REQ*STR_W-1:0] req_string,
  input  logic [N_REQ*8-1:0]     req_length,
  input  logic [N_REQ-1:0]       req_pulse,
  output logic [N_REQ-1:0]       req_pending,
  output logic [N_REQ-1:0]       req_done,
  output logic [N_REQ-1:0]       req_err,
  output logic                   grant_vld,
  output logic [2:0]             grant_id,
  output logic [STR_W-1:0]       m_tx_string,
  output logic [7:0]             m_tx_length,
  output logic                   m_tx_req,
  input  logic                   m_tx_busy,
  input  logic                   m_tx_done
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] pending_q;
  logic [2:0]       rr_ptr_q, grant_id_q, pick_idx;
  logic             pick_found, grant_vld_q, abort_q, abort_set;
  logic [31:0]      cnt_q;
  logic [STR_W-1:0] sel_string, m_tx_string_q;
  logic [7:0]       sel_length, m_tx_length_q;
  logic             timeout_hit, in_release;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .found   (pick_found),
    .index   (pick_idx)
  );

  // Strings are not buffered: the granted slot is muxed and captured once.
  assign sel_string  = req_string[int'(pick_idx)*STR_W +: STR_W];
  assign sel_length  = req_length[int'(pick_idx)*8 +: 8];
  assign timeout_hit = (cnt_q == 32'(TIMEOUT_CYC - 1));
  assign in_release  = (state_q == ST_RELEASE);

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    logic mine;
    logic pend_q;
    assign mine           = in_release && (grant_id_q == 3'(i));
    assign req_done[i]    = mine;
    assign req_err[i]     = mine & abort_q;
    assign pending_q[i]   = pend_q;
    // A re-post in the release cycle wins over the clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) pend_q <= 1'b0;
      else            pend_q <= req_pulse[i] | (pend_q & ~mine);
    end
  end

  always_comb begin
    state_d   = state_q;
    m_tx_req  = 1'b0;
    abort_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) state_d = (sel_length == 8'd0) ? ST_RELEASE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!m_tx_busy) begin
          m_tx_req = 1'b1;
          state_d  = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (m_tx_done)      state_d = ST_RELEASE;
        else if (m_tx_busy) state_d = ST_WAIT_DONE;
        else if (timeout_hit) begin
          state_d   = ST_RELEASE;
          abort_set = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (m_tx_done) state_d = ST_RELEASE;
        else if (timeout_hit) begin
          state_d   = ST_RELEASE;
          abort_set = 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_vld_q   <= 1'b0;
      abort_q       <= 1'b0;
      cnt_q         <= '0;
      m_tx_string_q <= '0;
      m_tx_length_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE)
        cnt_q <= cnt_q + 32'd1;

      if (state_q == ST_IDLE && pick_found) begin
        grant_id_q    <= pick_idx;
        grant_vld_q   <= 1'b1;
        m_tx_string_q <= sel_string;
        m_tx_length_q <= sel_length;
        abort_q       <= 1'b0;
      end
      if (abort_set) abort_q <= 1'b1;
      if (in_release) begin
        grant_vld_q <= 1'b0;
        abort_q     <= 1'b0;
        rr_ptr_q    <= 3'((int'(grant_id_q) + 1) % N_REQ);
      end
    end
  end

  assign req_pending = pending_q;
  assign grant_vld   = grant_vld_q;
  assign grant_id    = grant_id_q;
  assign m_tx_string = m_tx_string_q;
  assign m_tx_length = m_tx_length_q;

endmodule
